// File: rtl/poci_master.sv
// POCI bus master: turns one requester transfer into a SETUP/ACCESS bus cycle and returns a response.
// Latency: accept at edge N, SETUP N+1, ACCESS N+2 (+wait states), rsp_valid N+3 at zero wait.
// Backpressure: req_ready only in IDLE; a pending response is held stable until rsp_ready.
module poci_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic        psel,
  output logic        penable,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Last wait-counter value before the transfer is abandoned.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] wait_cnt;

  // Transfer sequencer; every bus and response output is a register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= 32'd0;
      pwdata      <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            paddr     <= {req_addr[31:2], 2'b00};
            pwrite    <= req_write;
            pwdata    <= req_wdata;
            psel      <= 1'b1;
            penable   <= 1'b0;
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= 16'd0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins over the timeout in the same cycle.
          if (pready) begin
            rsp_rdata   <= pwrite ? 32'd0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
